// File: rtl/audio_pkg.sv
// Shared types and helpers for the audio output scheduler.
// Latency: n/a (types, constants and a combinational saturating add).
// Backpressure: n/a.
//
// Contents:
//   AUDIO_WIDTH    sample width, two's complement
//   sched_state_t  scheduler FSM states
//   sample_t       signed audio sample
//   sat_add(a,b)   signed add clamped to the sample range
package audio_pkg;

   localparam int AUDIO_WIDTH = 16;

   typedef enum logic [2:0] {
      IDLE,
      POP,
      GEN,
      MIX,
      WRITE
   } sched_state_t;

   typedef logic signed [AUDIO_WIDTH-1:0] sample_t;

   // One guard bit is enough: if it disagrees with the sample sign bit the
   // true sum is outside the sample range, and the guard bit gives the sign.
   function automatic sample_t sat_add(input sample_t a, input sample_t b);
      logic signed [AUDIO_WIDTH:0] sum;
      sum = {a[AUDIO_WIDTH-1], a} + {b[AUDIO_WIDTH-1], b};
      if (sum[AUDIO_WIDTH] != sum[AUDIO_WIDTH-1])
         sat_add = sum[AUDIO_WIDTH] ? {1'b1, {(AUDIO_WIDTH-1){1'b0}}}
                                    : {1'b0, {(AUDIO_WIDTH-1){1'b1}}};
      else
         sat_add = sum[AUDIO_WIDTH-1:0];
   endfunction

endpackage

// File: rtl/audio_out_scheduler_fifo.sv
// Generic synchronous FIFO holding incoming audio samples.
// Latency: a pushed word is visible at o_head_dat the cycle after the push.
// Backpressure: pushes are ignored while full unless a pop happens in the same cycle.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   i_push, i_push_dat    write request and data
//   i_pop                 read request; the head word is consumed
//   o_head_dat            word at the head of the queue (fall-through)
//   o_full, o_empty       occupancy flags
//   o_level               occupancy, 0..DEPTH
module sample_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_push_dat,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_head_dat,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [LW-1:0]    r_level;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_full     = (r_level == LW'(DEPTH));
   assign o_empty    = (r_level == '0);
   assign o_level    = r_level;
   assign o_head_dat = r_mem[r_rd_ptr];

   // On a full FIFO the write lands in the slot being read this cycle; the
   // reader has already taken the old word, so the pair is safe.
   assign w_do_push = i_push & (~o_full | i_pop);
   assign w_do_pop  = i_pop & ~o_empty;

   always_ff @(posedge clk) begin
      if (w_do_push)
         r_mem[r_wr_ptr] <= i_push_dat;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_do_push)
            r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_do_pop)
            r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_level <= r_level + LW'(1);
            2'b01:   r_level <= r_level - LW'(1);
            default: r_level <= r_level;
         endcase
      end
   end

endmodule

// File: rtl/audio_out_scheduler.sv
// Feeds Audio_Controller's DAC: buffers STM32 samples, mixes in a square tone, paces tone-only output.
// Latency: raw stm_wr edge to write strobe is 6 cycles (2 sync, push, POP, MIX, WRITE).
// Backpressure: WRITE waits on audio_out_allowed; FIFO full drops new samples and sets overflow.
//
// Ports:
//   CLOCK_50, reset_n        clock, asynchronous active-low reset
//   stm_data, stm_wr         asynchronous STM32 sample bus and write strobe (rising edge = sample)
//   stm_ready                registered "FIFO not full"
//   tone_sel                 square tone select, 0 = off
//   audio_out_allowed        DAC path can accept a sample
//   left/right_channel_audio_out  mixed sample, identical on both channels
//   write_audio_out          one-cycle write strobe
//   fifo_level, overflow     FIFO occupancy, sticky drop flag
module audio_out_scheduler
   import audio_pkg::*;
#(
   parameter int FIFO_DEPTH   = 4,
   parameter int TONE_AMP     = 10000,
   parameter int SAMPLE_DIV   = 6250,
   parameter int IDLE_TIMEOUT = 12500
) (
   input  logic                          CLOCK_50,
   input  logic                          reset_n,
   input  logic [AUDIO_WIDTH-1:0]        stm_data,
   input  logic                          stm_wr,
   output logic                          stm_ready,
   input  logic [3:0]                    tone_sel,
   input  logic                          audio_out_allowed,
   output logic [AUDIO_WIDTH-1:0]        left_channel_audio_out,
   output logic [AUDIO_WIDTH-1:0]        right_channel_audio_out,
   output logic                          write_audio_out,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          overflow
);

   localparam int IW = $clog2(IDLE_TIMEOUT + 1);
   localparam int PW = $clog2(SAMPLE_DIV);

   logic [2:0]             r_wr_sync;
   logic [AUDIO_WIDTH-1:0] r_dat_d1;
   logic [AUDIO_WIDTH-1:0] r_dat_d2;
   logic                   w_wr_rise;
   logic                   w_push;
   logic                   w_drop;
   logic                   w_pop;
   logic                   w_full;
   logic                   w_empty;
   logic [AUDIO_WIDTH-1:0] w_head;

   sched_state_t           r_state;
   sched_state_t           w_state_nxt;
   logic                   w_write;
   logic                   w_gen_ok;

   logic [3:0]             r_tone_sel;
   logic [18:0]            r_tone_cnt;
   logic                   r_tone_neg;
   sample_t                w_tone;

   logic [IW-1:0]          r_idle_cnt;
   logic [PW-1:0]          r_pace_cnt;

   sample_t                r_sample;
   sample_t                r_chan;
   logic                   r_overflow;
   logic                   r_stm_ready;

   // ---------------- capture path ----------------
   // stm_data is delayed by two flops so it lines up with the synchronized
   // strobe; the STM holds it long enough for that to be safe.
   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_sync <= '0;
         r_dat_d1  <= '0;
         r_dat_d2  <= '0;
      end else begin
         r_wr_sync <= {r_wr_sync[1:0], stm_wr};
         r_dat_d1  <= stm_data;
         r_dat_d2  <= r_dat_d1;
      end
   end

   assign w_wr_rise = r_wr_sync[1] & ~r_wr_sync[2];
   assign w_push    = w_wr_rise & (~w_full | w_pop);
   assign w_drop    = w_wr_rise & w_full & ~w_pop;

   sample_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (AUDIO_WIDTH)
   ) u_fifo (
      .clk        (CLOCK_50),
      .rst_n      (reset_n),
      .i_push     (w_push),
      .i_push_dat (r_dat_d2),
      .i_pop      (w_pop),
      .o_head_dat (w_head),
      .o_full     (w_full),
      .o_empty    (w_empty),
      .o_level    (fifo_level)
   );

   // ---------------- tone generator ----------------
   // While the tone is off the counter is parked at 0 with phase +, so a newly
   // selected tone always starts a fresh positive half-period. Once running,
   // a new nonzero selection is only picked up at a phase toggle.
   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         r_tone_sel <= '0;
         r_tone_cnt <= '0;
         r_tone_neg <= 1'b0;
      end else if (tone_sel == 4'd0) begin
         r_tone_sel <= '0;
         r_tone_cnt <= '0;
         r_tone_neg <= 1'b0;
      end else if (r_tone_sel == 4'd0) begin
         r_tone_sel <= tone_sel;
         r_tone_cnt <= '0;
      end else if (r_tone_cnt == {r_tone_sel, 15'd3000}) begin
         r_tone_cnt <= '0;
         r_tone_neg <= ~r_tone_neg;
         r_tone_sel <= tone_sel;
      end else begin
         r_tone_cnt <= r_tone_cnt + 19'd1;
      end
   end

   assign w_tone = (r_tone_sel == 4'd0) ? sample_t'(0)
                 : (r_tone_neg ? sample_t'(-TONE_AMP) : sample_t'(TONE_AMP));

   // ---------------- idle / pace counters ----------------
   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         r_idle_cnt <= '0;
         r_pace_cnt <= '0;
      end else begin
         if (w_push)
            r_idle_cnt <= '0;
         else if (w_empty && (r_idle_cnt != IW'(IDLE_TIMEOUT)))
            r_idle_cnt <= r_idle_cnt + IW'(1);
         r_pace_cnt <= (r_pace_cnt == PW'(SAMPLE_DIV - 1)) ? '0 : r_pace_cnt + PW'(1);
      end
   end

   assign w_gen_ok = (r_tone_sel != 4'd0) &&
                     (r_idle_cnt == IW'(IDLE_TIMEOUT)) &&
                     (r_pace_cnt == PW'(SAMPLE_DIV - 1));

   // ---------------- scheduler FSM ----------------
   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n)
         r_state <= IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      w_write     = 1'b0;
      case (r_state)
         IDLE: begin
            // Stream samples win over generated ones.
            if (!w_empty)
               w_state_nxt = POP;
            else if (w_gen_ok)
               w_state_nxt = GEN;
         end
         POP: begin
            w_pop       = 1'b1;
            w_state_nxt = MIX;
         end
         GEN:   w_state_nxt = MIX;
         MIX:   w_state_nxt = WRITE;
         WRITE: begin
            if (audio_out_allowed) begin
               w_write     = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // ---------------- datapath and status ----------------
   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         r_sample    <= '0;
         r_chan      <= '0;
         r_overflow  <= 1'b0;
         r_stm_ready <= 1'b1;
      end else begin
         case (r_state)
            POP:     r_sample <= w_head;
            GEN:     r_sample <= '0;
            MIX:     r_chan   <= sat_add(r_sample, w_tone);
            default: r_sample <= r_sample;
         endcase
         if (w_drop)
            r_overflow <= 1'b1;
         r_stm_ready <= ~w_full;
      end
   end

   // The strobe is decoded from the state register, so reset removes it
   // without waiting for a clock edge.
   assign write_audio_out         = w_write;
   assign left_channel_audio_out  = r_chan;
   assign right_channel_audio_out = r_chan;
   assign overflow                = r_overflow;
   assign stm_ready               = r_stm_ready;

endmodule
